// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI-Stream sample type, framer states and packet sizing helper
package axis_pkg;
   typedef logic signed [15:0] sample_t;
   typedef enum logic {IDLE, RUN} pkt_state_e;
   function automatic int pack_beats(input int max_pack_size, input int bus_num);
      return max_pack_size / bus_num;
   endfunction
endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry fully registered AXIS slice with registered in_ready
module axis_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         main_v_q, main_v_d, skid_v_q, skid_v_d, ready_q, ready_d;
   logic [W-1:0] main_q, main_d, skid_q, skid_d;
   logic         fire, pop;
   always_comb begin
      fire     = in_valid && ready_q;
      pop      = main_v_q && out_ready;
      main_v_d = main_v_q;
      main_d   = main_q;
      skid_v_d = skid_v_q;
      skid_d   = skid_q;
      if (!main_v_q || pop) begin
         main_v_d = skid_v_q || fire;
         main_d   = skid_v_q ? skid_q : fire ? in_data : main_q;
         skid_v_d = skid_v_q && fire;
         skid_d   = (skid_v_q && fire) ? in_data : skid_q;
      end else if (fire) begin
         skid_v_d = 1'b1;
         skid_d   = in_data;
      end
      ready_d = !skid_v_d;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         ready_q  <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else begin
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         ready_q  <= ready_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
      end
   end
   assign in_ready  = ready_q;
   assign out_valid = main_v_q;
   assign out_data  = main_q;
endmodule

// File: rtl/axis_packetizer.sv
// axis_packetizer: frames a multi-lane sample stream into packets with SOP (tuser) and EOP (tlast)
module axis_packetizer
   import axis_pkg::*;
#(
   parameter int MAX_PACK_SIZE = 8192,
   parameter int BUS_NUM       = 2,
   parameter int LEN_W         = $clog2(pack_beats(MAX_PACK_SIZE, BUS_NUM)) + 1,
   parameter int PKT_CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [LEN_W-1:0]         cfg_len,
   input  logic                     in_tvalid,
   output logic                     in_tready,
   input  sample_t [BUS_NUM-1:0]    in_tdata,
   output logic                     out_tvalid,
   input  logic                     out_tready,
   output sample_t [BUS_NUM-1:0]    out_tdata,
   output logic                     out_tlast,
   output logic                     out_tuser,
   output logic                     busy,
   output logic [PKT_CNT_W-1:0]     pkt_cnt
);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(pack_beats(MAX_PACK_SIZE, BUS_NUM));
   localparam int               PW      = BUS_NUM * $bits(sample_t) + 2;
   pkt_state_e           state_q, state_d;
   logic [LEN_W-1:0]     cnt_q, cnt_d, len_q, len_d, eff_len, cur_len, idx;
   logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic                 gate, sb_ready, accept, first, last;
   logic [PW-1:0]        sb_out;
   // An open packet always runs to completion; en only gates the start of a new one
   always_comb begin
      eff_len   = (cfg_len == '0 || cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
      gate      = state_q == RUN || en;
      accept    = in_tvalid && sb_ready && gate;
      cur_len   = state_q == RUN ? len_q : eff_len;
      idx       = state_q == RUN ? cnt_q : '0;
      first     = idx == '0;
      last      = idx == cur_len - LEN_W'(1);
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      pkt_cnt_d = pkt_cnt_q;
      if (accept) begin
         state_d   = last ? IDLE : RUN;
         cnt_d     = last ? '0 : idx + LEN_W'(1);
         len_d     = cur_len;
         pkt_cnt_d = last ? pkt_cnt_q + PKT_CNT_W'(1) : pkt_cnt_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end
   axis_skid_buf #(.W(PW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_tvalid && gate),
      .in_ready  (sb_ready),
      .in_data   ({first, last, in_tdata}),
      .out_valid (out_tvalid),
      .out_ready (out_tready),
      .out_data  (sb_out)
   );
   assign {out_tuser, out_tlast, out_tdata} = sb_out;
   assign in_tready = sb_ready && gate;
   assign busy      = state_q == RUN;
   assign pkt_cnt   = pkt_cnt_q;
endmodule

// File: tb/tb_axis_packetizer.sv
// tb_axis_packetizer: directed framing scenarios with a queue scoreboard and independent output monitor
module tb_axis_packetizer;
   import axis_pkg::*;
   logic            clk = 1'b0, rst_n = 1'b0, en = 1'b0, in_tvalid = 1'b0, out_tready = 1'b0;
   logic [12:0]     cfg_len = '0;
   sample_t [1:0]   in_tdata = '0, out_tdata;
   logic            in_tready, out_tvalid, out_tlast, out_tuser, busy;
   logic [15:0]     pkt_cnt;
   logic [33:0]     q[$];
   logic [33:0]     prev_pay;
   bit              rnd = 1'b0, prev_stall = 1'b0;
   int              checks = 0, errors = 0;
   time             t_acc, t_first;

   axis_packetizer dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_len(cfg_len),
      .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
      .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
      .out_tlast(out_tlast), .out_tuser(out_tuser), .busy(busy), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1 out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (!rst_n) prev_stall = 1'b0;
      else begin
         if (prev_stall) chk("stall_stable", {out_tvalid, out_tuser, out_tlast, out_tdata}, {1'b1, prev_pay});
         if (out_tvalid && out_tready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %0h expected none", {out_tuser, out_tlast, out_tdata});
            end else chk("beat", {out_tuser, out_tlast, out_tdata}, q.pop_front());
         end
         prev_stall = out_tvalid && !out_tready;
         prev_pay   = {out_tuser, out_tlast, out_tdata};
      end
   end

   task automatic send(input logic [31:0] d, input bit u, input bit l);
      bit acc = 1'b0;
      int n = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         in_tvalid = 1'b1;
         in_tdata  = d;
         #1 acc = in_tready;
         if (acc) q.push_back({u, l, d});
         @(posedge clk);
         n++;
      end
      t_acc = $time;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no in_tready expected accept of %0h", d);
         in_tvalid = 1'b0;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_tvalid = 1'b0;
   endtask

   task automatic drain(input int exp_pkts);
      int n = 0;
      idle();
      while ((q.size() != 0 || out_tvalid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", q.size(), 0);
      chk("pkt_cnt", pkt_cnt, exp_pkts);
   endtask

   initial begin
      #7;
      chk("rst_tvalid", out_tvalid, 0);
      chk("rst_tlast", out_tlast, 0);
      chk("rst_tuser", out_tuser, 0);
      chk("rst_tdata", out_tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_tready", in_tready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      cfg_len = 13'd4;
      // 12 beats of length-4 packets, back to back
      for (int i = 0; i < 12; i++) begin
         send(32'h1000 + 32'(i), i % 4 == 0, i % 4 == 3);
         if (i == 0) t_first = t_acc;
      end
      chk("rate", t_acc - t_first, 110);
      drain(3);
      cfg_len = 13'd1;
      for (int i = 0; i < 5; i++) begin
         send(32'h2000 + 32'(i), 1'b1, 1'b1);
         #1 chk("len1_pkt_cnt", pkt_cnt, 4 + i);
      end
      drain(8);
      cfg_len = 13'd4;
      for (int i = 0; i < 3; i++) send(32'h3000 + 32'(i), i == 0, 1'b0);
      #1 cfg_len = 13'd6;
      send(32'h3003, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) send(32'h3100 + 32'(i), i == 0, i == 5);
      drain(10);
      cfg_len = 13'd4;
      send(32'h4000, 1'b1, 1'b0);
      send(32'h4001, 1'b0, 1'b0);
      #1 chk("busy_mid", busy, 1);
      en = 1'b0;
      send(32'h4002, 1'b0, 1'b0);
      send(32'h4003, 1'b0, 1'b1);
      #1 chk("en_off_tready", in_tready, 0);
      chk("en_off_busy", busy, 0);
      @(negedge clk);
      #1 chk("en_off_hold", in_tready, 0);
      drain(11);
      en = 1'b1;
      cfg_len = 13'd3;
      rnd = 1'b1;
      for (int i = 0; i < 300; i++) send($urandom, i % 3 == 0, i % 3 == 2);
      drain(111);
      rnd = 1'b0;
      cfg_len = 13'd8;
      for (int i = 0; i < 3; i++) send(32'h6000 + 32'(i), i == 0, 1'b0);
      #1 rst_n = 1'b0;
      in_tvalid = 1'b0;
      q.delete();
      #1 chk("mid_rst_tvalid", out_tvalid, 0);
      chk("mid_rst_tlast", out_tlast, 0);
      chk("mid_rst_tuser", out_tuser, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pkt_cnt", pkt_cnt, 0);
      chk("mid_rst_tready", in_tready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) send(32'h6100 + 32'(i), i == 0, i == 7);
      drain(1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
